// File: rtl/prom_programmer.sv
// Bit-serial fuse PROM word programmer: pulses each missing 1 bit, verifies it, then checks the whole word.
// Define PROM_PRECHECK_EN to reject words that would need a blown fuse cleared, before any pulse.
module prom_programmer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_ATTEMPTS  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [3:0]               operation,
  output logic [DATA_WIDTH-1:0]    prog_bit_sel,
  output logic                     prog_pulse,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               error_code
);
  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST    = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       ATTEMPT_LIMIT = 4'(MAX_ATTEMPTS);
  localparam logic [3:0] OP_DESELECT = 4'b0000;
  localparam logic [3:0] OP_READ     = 4'b1100;
  localparam logic [3:0] OP_PROG     = 4'b0011;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_IRREV    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISMATCH = 2'b11;
  localparam logic [DATA_WIDTH-1:0] ONE_BIT = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE    = 4'd0, SETUP  = 4'd1, SAMPLE = 4'd2, PULSE = 4'd3, RECOVER = 4'd4,
    VERIFY  = 4'd5, FINAL  = 4'd6, DONE   = 4'd7, FAIL  = 4'd8
  } state_t;

  // Returns {found, index} of the lowest set bit of mask.
  function automatic logic [BIT_W:0] lowest_bit(input logic [DATA_WIDTH-1:0] mask);
    logic [BIT_W:0] r;
    r = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, BIT_W'(i)};
      else         r = r;
    end
    return r;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [3:0]            attempt_r, attempt_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [DATA_WIDTH-1:0] target_r, target_s, sample_r, sample_s;
  logic [ADDRESS_WIDTH-1:0] addr_s;
  logic [1:0]            code_s;
  logic [3:0]            op_s;
  logic [DATA_WIDTH-1:0] sel_s;
  logic                  pulse_s, busy_s, done_s, err_s, irrev_s;
  logic [DATA_WIDTH-1:0] above_s;
  logic [BIT_W:0]        sample_pick_s, verify_pick_s;

  // Only bits above the one just verified are candidates, so the walk always moves upward.
  assign above_s       = ~((ONE_BIT << (bit_r + BIT_W'(1))) - ONE_BIT);
  assign sample_pick_s = lowest_bit(target_r & ~data_line_in);
  assign verify_pick_s = lowest_bit(target_r & ~data_line_in & above_s);
`ifdef PROM_PRECHECK_EN
  assign irrev_s = |(data_line_in & ~target_r);
`else
  assign irrev_s = 1'b0;
`endif

  // Next-state logic plus decode of the registered chip-facing outputs.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    attempt_s = attempt_r;
    bit_s     = bit_r;
    target_s  = target_r;
    sample_s  = sample_r;
    addr_s    = address_line;
    code_s    = error_code;
    case (state_r)
      IDLE: begin
        if (start) begin
          target_s  = data_in;
          addr_s    = address_in;
          code_s    = ERR_NONE;
          attempt_s = 4'd0;
          cnt_s     = '0;
          state_s   = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = '0;
          state_s = SAMPLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      SAMPLE: begin
        sample_s = data_line_in;
        if (irrev_s) begin
          code_s  = ERR_IRREV;
          state_s = FAIL;
        end else if (sample_pick_s[BIT_W]) begin
          bit_s   = sample_pick_s[BIT_W-1:0];
          cnt_s   = '0;
          state_s = PULSE;
        end else begin
          state_s = FINAL;
        end
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          cnt_s   = '0;
          state_s = RECOVER;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = '0;
          state_s = VERIFY;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      VERIFY: begin
        sample_s = data_line_in;
        cnt_s    = '0;
        if (data_line_in[bit_r]) begin
          attempt_s = 4'd0;
          if (verify_pick_s[BIT_W]) begin
            bit_s   = verify_pick_s[BIT_W-1:0];
            state_s = PULSE;
          end else begin
            state_s = FINAL;
          end
        end else begin
          attempt_s = attempt_r + 4'd1;
          if ((attempt_r + 4'd1) == ATTEMPT_LIMIT) begin
            code_s  = ERR_TIMEOUT;
            state_s = FAIL;
          end else begin
            state_s = PULSE;
          end
        end
      end
      FINAL: begin
        if (sample_r == target_r) begin
          state_s = DONE;
        end else begin
          code_s  = ERR_MISMATCH;
          state_s = FAIL;
        end
      end
      DONE:    state_s = IDLE;
      FAIL:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    op_s    = OP_DESELECT;
    sel_s   = '0;
    pulse_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_s)
      SETUP, SAMPLE, RECOVER, VERIFY, FINAL: begin
        op_s   = OP_READ;
        busy_s = 1'b1;
      end
      PULSE: begin
        op_s    = OP_PROG;
        sel_s   = ONE_BIT << bit_s;
        pulse_s = 1'b1;
        busy_s  = 1'b1;
      end
      DONE:    done_s = 1'b1;
      FAIL:    err_s  = 1'b1;
      default: op_s   = OP_DESELECT;
    endcase
  end

  // State, datapath and output registers; reset drops the programming driver on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      attempt_r    <= 4'd0;
      bit_r        <= '0;
      target_r     <= '0;
      sample_r     <= '0;
      address_line <= '0;
      error_code   <= ERR_NONE;
      operation    <= OP_DESELECT;
      prog_bit_sel <= '0;
      prog_pulse   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      attempt_r    <= attempt_s;
      bit_r        <= bit_s;
      target_r     <= target_s;
      sample_r     <= sample_s;
      address_line <= addr_s;
      error_code   <= code_s;
      operation    <= op_s;
      prog_bit_sel <= sel_s;
      prog_pulse   <= pulse_s;
      busy         <= busy_s;
      done         <= done_s;
      error        <= err_s;
    end
  end
endmodule

// File: tb/tb_prom_programmer.sv
// Self-checking bench for prom_programmer: fuse-chip model, directed table, random words vs. a word-level model.
module tb_prom_programmer;
  localparam int DW = 8, AW = 9, P = 16, S = 4, MAXA = 4;
`ifdef PROM_PRECHECK_EN
  localparam bit PRECHECK = 1'b1;
`else
  localparam bit PRECHECK = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW-1:0] address_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_line_in;
  logic [AW-1:0] address_line;
  logic [3:0]    operation;
  logic [DW-1:0] prog_bit_sel;
  logic          prog_pulse, busy, done, error;
  logic [1:0]    error_code;

  always #5 clk = ~clk;

  prom_programmer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .PULSE_CYCLES(P),
                    .SETTLE_CYCLES(S), .MAX_ATTEMPTS(MAXA)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .address_in(address_in),
    .data_in(data_in), .data_line_in(data_line_in), .address_line(address_line),
    .operation(operation), .prog_bit_sel(prog_bit_sel), .prog_pulse(prog_pulse),
    .busy(busy), .done(done), .error(error), .error_code(error_code));

  int tests = 0, fails = 0;
  logic [DW-1:0] chip_word = '0;
  int need_arr[DW];
  int hits[DW];
  int pulse_bits[$];
  int exp_bits[$];
  int plen = 0, cur_bit = 0, safety_viol = 0;

  // Chip drives its fuses only in read mode.
  assign data_line_in = (operation == 4'b1100) ? chip_word : '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Chip model: a fuse blows once its bit has received need_arr[] complete pulses (0 = never).
  always @(negedge clk) begin
    if (prog_pulse && operation != 4'b0011) safety_viol++;
    if (prog_pulse && $countones(prog_bit_sel) != 1) safety_viol++;
    if (!prog_pulse && prog_bit_sel != '0) safety_viol++;
    if (!reset_n) begin
      plen = 0;
    end else if (prog_pulse) begin
      plen++;
      for (int b = 0; b < DW; b++) if (prog_bit_sel[b]) cur_bit = b;
    end else if (plen > 0) begin
      tests++;
      if (plen != P) begin
        fails++;
        $display("FAIL pulse_len: got %0d cycles, expected %0d", plen, P);
      end
      pulse_bits.push_back(cur_bit);
      hits[cur_bit]++;
      if (need_arr[cur_bit] != 0 && hits[cur_bit] >= need_arr[cur_bit]) chip_word[cur_bit] = 1'b1;
      plen = 0;
    end
  end

  // Word-level reference: pulse every missing 1 in ascending order, up to MAXA tries each.
  task automatic model_run(input logic [DW-1:0] c0, input logic [DW-1:0] t, input int sb, input int sn,
                           output bit ok, output logic [1:0] code, output int np, output int lat);
    logic [DW-1:0] c;
    bit set;
    int need;
    exp_bits.delete();
    c = c0; ok = 1'b1; code = 2'b00; np = 0; lat = S + 1;
    if (PRECHECK && (c0 & ~t) != '0) begin
      ok = 1'b0; code = 2'b01;
      return;
    end
    for (int b = 0; b < DW; b++) begin
      if (t[b] && !c[b]) begin
        need = (b == sb) ? sn : 1;
        set = 1'b0;
        for (int k = 1; k <= MAXA; k++) begin
          exp_bits.push_back(b);
          np++;
          lat += P + S + 1;
          if (need != 0 && k >= need) begin
            set = 1'b1;
            break;
          end
        end
        if (!set) begin
          ok = 1'b0; code = 2'b10;
          return;
        end
        c[b] = 1'b1;
      end
    end
    lat += 1;
    if (c != t) begin
      ok = 1'b0; code = 2'b11;
    end
  endtask

  task automatic run_vec(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] init,
                         input logic [DW-1:0] d, input int sb, input int sn, input int inject,
                         input bit e_ok, input logic [1:0] e_code, input int e_np, input int e_lat);
    int lat;
    bit seq_ok;
    chip_word = init;
    pulse_bits.delete();
    for (int b = 0; b < DW; b++) begin
      hits[b] = 0;
      need_arr[b] = (b == sb) ? sn : 1;
    end
    @(negedge clk);
    start = 1'b1; address_in = a; data_in = d;
    @(posedge clk); #1;
    start = 1'b0; address_in = ~a; data_in = ~d;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " code_cleared"}, error_code, 0);
    lat = 0;
    while (!(done || error) && lat < 2000) begin
      start = (lat == inject);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (lat >= 2000) begin
      check({tag, " completion_timeout"}, lat, 0);
      return;
    end
    check({tag, " done"}, done, e_ok);
    check({tag, " error"}, error, !e_ok);
    check({tag, " error_code"}, error_code, e_code);
    check({tag, " pulses"}, pulse_bits.size(), e_np);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " address_line"}, address_line, a);
    check({tag, " end_state"}, {busy, prog_pulse, operation}, 0);
    seq_ok = (pulse_bits.size() == exp_bits.size());
    for (int i = 0; i < pulse_bits.size() && seq_ok; i++) if (pulse_bits[i] != exp_bits[i]) seq_ok = 1'b0;
    check({tag, " pulse_order"}, seq_ok, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " code_held"}, {done, error, error_code}, {2'b00, e_code});
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] init;
    logic [DW-1:0] data;
    int            slow_bit;
    int            slow_need;
    int            inject;
    bit            exp_ok;
    logic [1:0]    exp_code;
    int            exp_pulses;
    int            exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit ok;
    logic [1:0] code;
    int np, lat, n, bad;
    logic [AW-1:0] ra;
    logic [DW-1:0] ri, rt;
    int rsb, rsn;

    vecs[0] = '{9'h1A5, 8'h00, 8'h81, -1, 0, 10, 1'b1, 2'b00, 2, 48};
    vecs[1] = '{9'h033, 8'h5A, 8'h5A, -1, 0, -1, 1'b1, 2'b00, 0, 6};
    vecs[2] = '{9'h100, 8'h00, 8'h08, 3, 3, -1, 1'b1, 2'b00, 3, 69};
    vecs[3] = '{9'h101, 8'h00, 8'h08, 3, 0, -1, 1'b0, 2'b10, 4, 89};
    vecs[4] = PRECHECK ? '{9'h0C3, 8'h01, 8'h02, -1, 0, -1, 1'b0, 2'b01, 0, 5}
                       : '{9'h0C3, 8'h01, 8'h02, -1, 0, -1, 1'b0, 2'b11, 1, 27};
    vecs[5] = PRECHECK ? '{9'h1FF, 8'hFF, 8'h00, -1, 0, -1, 1'b0, 2'b01, 0, 5}
                       : '{9'h1FF, 8'hFF, 8'h00, -1, 0, -1, 1'b0, 2'b11, 0, 6};
    vecs[6] = '{9'h000, 8'h00, 8'hFF, -1, 0, -1, 1'b1, 2'b00, 8, 174};
    vecs[7] = '{9'h055, 8'h00, 8'h01, 0, 4, -1, 1'b1, 2'b00, 4, 90};
    vecs[8] = '{9'h0AA, 8'h24, 8'hA6, -1, 0, -1, 1'b1, 2'b00, 2, 48};
    vecs[9] = '{9'h123, 8'h00, 8'h0F, 2, 0, -1, 1'b0, 2'b10, 6, 131};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {address_line, operation, prog_bit_sel, prog_pulse, busy, done, error, error_code}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      model_run(vecs[i].init, vecs[i].data, vecs[i].slow_bit, vecs[i].slow_need, ok, code, np, lat);
      run_vec($sformatf("vec%0d", i), vecs[i].addr, vecs[i].init, vecs[i].data, vecs[i].slow_bit,
              vecs[i].slow_need, vecs[i].inject, vecs[i].exp_ok, vecs[i].exp_code,
              vecs[i].exp_pulses, vecs[i].exp_lat);
    end

    for (int i = 0; i < 20; i++) begin
      ra  = 9'($urandom);
      rt  = 8'($urandom);
      ri  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & rt);
      rsb = $urandom_range(0, DW - 1);
      rsn = $urandom_range(0, 5);
      model_run(ri, rt, rsb, rsn, ok, code, np, lat);
      run_vec($sformatf("rand%0d", i), ra, ri, rt, rsb, rsn, -1, ok, code, np, lat);
    end

    // Reset during the 5th cycle of a pulse must kill the pulse with no resumption.
    chip_word = '0;
    for (int b = 0; b < DW; b++) begin
      hits[b] = 0;
      need_arr[b] = 1;
    end
    @(negedge clk);
    start = 1'b1; address_in = 9'h0F0; data_in = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!prog_pulse && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midreset pulse_seen", prog_pulse, 1);
    repeat (4) @(negedge clk);
    check("midreset still_pulsing", prog_pulse, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset outputs", {prog_pulse, busy, operation, prog_bit_sel}, 0);
    check("midreset idle_regs", {address_line, done, error, error_code}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (prog_pulse || busy || operation != 4'b0000) bad++;
    end
    check("midreset no_resume", bad, 0);

    check("safety_monitor", safety_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
